// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one sequential read per cycle to instruction memory, captures each
// response one cycle later into a small circular fetch queue, and hands the
// queue head to decode with a valid/ready handshake. A redirect replaces the
// PC and flushes everything queued or in flight. Issue is credit-limited so
// queued plus in-flight entries never exceed QDEPTH.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- misaligned redirect
// targets raise a sticky misalign_fault and halt fetch until the next aligned
// redirect or reset. Without it, target bits [1:0] are cleared on load.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_fault
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(QDEPTH);

  // PC loaded on a redirect; the trap build keeps the raw target so the
  // fault decision can see the low bits, the plain build drops them.
  function automatic logic [XLEN-1:0] load_pc(input logic [XLEN-1:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return t & ~XLEN'(3);
`endif
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] t);
    return t[1:0] != 2'b00;
  endfunction

  logic [XLEN-1:0] pc_p0;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [31:0]     q_instr [QDEPTH];
  logic [XLEN-1:0] q_pc    [QDEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            halted;
  logic            push;
  logic            pop;

  // Credits: entries queued plus the one response that may be in flight.
  assign used      = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign imem_req  = !reset && !redirect_valid && !halted && (used < DEPTH_C);
  assign imem_addr = pc_p0;

  // A redirect discards the response arriving this cycle and blocks the pop.
  assign push      = vld_p1 && !redirect_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_instr = out_valid ? q_instr[rptr] : '0;
  assign out_pc    = out_valid ? q_pc[rptr]    : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_fault = halted;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= is_misaligned(redirect_target);
    end
  end
`else
  assign halted = 1'b0;
`endif

  // ---- stage p0: PC register, advances on every issued request ----
  // PC update: redirect wins, otherwise step by 4 per request (wraps freely).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      pc_p0 <= load_pc(redirect_target);
    end else if (imem_req) begin
      pc_p0 <= pc_p0 + XLEN'(4);
    end
  end

  // ---- stage p1: request in flight, response arrives on imem_rdata ----
  // In-flight flag; a redirect cycle never issues, so it also clears here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= imem_req;
    end
  end

  // PC that travels with the in-flight request (data, not reset).
  always_ff @(posedge clk) begin
    if (imem_req) begin
      pc_p1 <= pc_p0;
    end
  end

  // ---- stage p2: fetch queue, head presented to decode ----
  // Queue storage written at the tail when a response lands.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wptr] <= imem_rdata;
      q_pc[wptr]    <= pc_p1;
    end
  end

  // Queue pointers and occupancy; redirect flushes ahead of push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (XLEN=64, QDEPTH=4).
// A reference model tracks, in program order, every request issued since the
// last flush together with its issue cycle: a request may issue while fewer
// than QDEPTH such entries exist, and the oldest one becomes visible two
// cycles after issue. Every cycle the DUT outputs are compared to that model.
module tb_fetch_unit;
  localparam int XLEN   = 64;
  localparam int QDEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_fault;
`endif

  fetch_unit #(.XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC('0)) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_fault(misalign_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [XLEN-1:0] a);
    return {a[26:2], 7'h13};
  endfunction

  // Instruction memory: answers one cycle after each request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [XLEN-1:0] pc;
    int              cyc;
  } ent_t;

  ent_t            q[$];
  logic [XLEN-1:0] m_pc;
  bit              m_halt;
  int              now;
  int              checks = 0;
  int              errors = 0;

  logic            s_req;
  logic [XLEN-1:0] s_addr;
  logic            s_valid;
  logic [XLEN-1:0] s_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, now);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic step(input bit rv, input logic [XLEN-1:0] tgt, input bit rdy);
    bit e_req;
    bit e_valid;
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = rdy;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_pc    = out_pc;
    e_req   = !rv && !m_halt && (q.size() < QDEPTH);
    e_valid = (q.size() > 0) && (q[0].cyc <= now - 2);
    chk("imem_req", 64'(s_req), 64'(e_req));
    if (e_req) chk("imem_addr", s_addr, m_pc);
    chk("out_valid", 64'(s_valid), 64'(e_valid));
    if (e_valid) begin
      chk("out_pc", s_pc, q[0].pc);
      chk("out_instr", 64'(out_instr), 64'(instr_of(q[0].pc)));
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_fault", 64'(misalign_fault), 64'(m_halt));
`endif
    if (rv) begin
      q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_halt = (tgt[1:0] != 2'b00);
      m_pc   = tgt;
`else
      m_pc   = tgt & ~64'd3;
`endif
    end else begin
      if (e_valid && rdy) void'(q.pop_front());
      if (e_req) begin
        q.push_back('{pc: m_pc, cyc: now});
        m_pc = m_pc + 64'd4;
      end
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_fault", 64'(misalign_fault), 64'd0);
`endif
    @(posedge clk);
    #1;
    reset  = 1'b0;
    q.delete();
    m_pc   = '0;
    m_halt = 1'b0;
  endtask

  typedef struct {
    bit              rv;
    logic [XLEN-1:0] tgt;
    bit              rdy;
    bit              e_req;
    logic [XLEN-1:0] e_addr;
    bit              e_valid;
    logic [XLEN-1:0] e_pc;
  } vec_t;

  initial begin
    vec_t tv[11];
    int   nreq;
    bit   rv;
    bit   rdy;
    logic [XLEN-1:0] tgt;

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    out_ready = 1'b0;
    now = 0;
    m_pc = '0;
    m_halt = 1'b0;

    // Reset release, streaming, stall, then redirect to 0x18 with 3 queued.
    tv[0]  = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h0,  1'b0, 64'h0};
    tv[1]  = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h4,  1'b0, 64'h0};
    tv[2]  = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h8,  1'b1, 64'h0};
    tv[3]  = '{1'b0, 64'h0,  1'b1, 1'b1, 64'hC,  1'b1, 64'h4};
    tv[4]  = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h10, 1'b1, 64'h8};
    tv[5]  = '{1'b0, 64'h0,  1'b0, 1'b1, 64'h14, 1'b1, 64'h8};
    tv[6]  = '{1'b1, 64'h18, 1'b0, 1'b0, 64'h0,  1'b1, 64'h8};
    tv[7]  = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h18, 1'b0, 64'h0};
    tv[8]  = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h1C, 1'b0, 64'h0};
    tv[9]  = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h20, 1'b1, 64'h18};
    tv[10] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h24, 1'b1, 64'h1C};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tv[i].rv, tv[i].tgt, tv[i].rdy);
      chk("tv_req", 64'(s_req), 64'(tv[i].e_req));
      if (tv[i].e_req) chk("tv_addr", s_addr, tv[i].e_addr);
      chk("tv_valid", 64'(s_valid), 64'(tv[i].e_valid));
      if (tv[i].e_valid) chk("tv_pc", s_pc, tv[i].e_pc);
    end

    // Ten stalled cycles after a flush: exactly QDEPTH requests, then drain.
    step(1'b1, 64'h100, 1'b0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0);
      nreq += int'(s_req);
    end
    chk("stall_reqs", 64'(nreq), 64'(QDEPTH));
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Redirect together with a pop and a landing response.
    step(1'b1, 64'h400, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("redir_valid_next", 64'(s_valid), 64'd0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("redir_first_pc", s_pc, 64'h400);

    // PC wrap-around at the top of the address space.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("wrap_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, '0, 1'b1);
    chk("wrap_addr1", s_addr, 64'h0);
    step(1'b0, '0, 1'b1);
    chk("wrap_addr2", s_addr, 64'h4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect halts fetch until an aligned redirect.
    step(1'b1, 64'h6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      chk("trap_req", 64'(s_req), 64'd0);
      chk("trap_fault", 64'(misalign_fault), 64'd1);
    end
    step(1'b1, 64'h20, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("trap_clear", 64'(misalign_fault), 64'd0);
    chk("trap_resume", s_addr, 64'h20);
`else
    // Low target bits are dropped when the PC is loaded.
    step(1'b1, 64'h206, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("align_addr", s_addr, 64'h204);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Mid-operation reset, then restart from RESET_PC.
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1);
    chk("rerst_addr", s_addr, 64'h0);
    chk("rerst_req", 64'(s_req), 64'd1);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 800; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      tgt = {$urandom, $urandom};
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
`endif
      rdy = ($urandom_range(0, 3) != 0);
      step(rv, tgt, rdy);
      if (i == 400) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 64: PC and address width in bits.
REQ-002 Parameter QDEPTH, default 4: fetch-queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port redirect_valid, input, 1: branch/jump taken; replace PC this cycle.
REQ-007 Port redirect_target, input, XLEN: new PC, sampled when redirect_valid=1.
REQ-008 Port imem_req, output, 1: instruction-memory read request this cycle.
REQ-009 Port imem_addr, output, XLEN: byte address of the request, equal to the current PC.
REQ-010 Port imem_rdata, input, 32: instruction word, valid exactly one cycle after imem_req=1.
REQ-011 Port out_valid, output, 1: fetch queue non-empty.
REQ-012 Port out_ready, input, 1: decode accepts the head entry.
REQ-013 Port out_instr, output, 32: instruction at the queue head.
REQ-014 Port out_pc, output, XLEN: PC of the queue-head instruction.
REQ-015 Port misalign_fault, output, 1: present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-016 imem_req SHALL be 1 when redirect_valid=0, fetch is not halted, and (queue count + in-flight count) < QDEPTH; otherwise 0.
REQ-017 On each cycle with imem_req=1, PC SHALL advance by 4 modulo 2^XLEN (wrap-around from all-ones to 0 is legal).
REQ-018 The response to a request issued in cycle N SHALL be written, together with its PC, into the queue tail at the end of cycle N+1.
REQ-019 Minimum latency from imem_req to out_valid SHALL be 2 cycles; throughput SHALL be 1 instruction/cycle while out_ready=1.
REQ-020 An entry SHALL be popped when out_valid=1 and out_ready=1; out_instr and out_pc SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged; the credit rule in REQ-016 SHALL make overflow impossible.
REQ-022 On redirect_valid=1: PC <= redirect_target, all queue entries flushed, any in-flight response discarded, imem_req=0 that cycle.
REQ-023 Redirect SHALL take priority over a simultaneous push, pop or issue; out_valid SHALL be 0 in the cycle after a redirect.
REQ-024 The first request to redirect_target SHALL be issued the cycle after redirect_valid, if the REQ-016 condition holds.
REQ-025 The queue SHALL use circular read/write pointers that wrap modulo QDEPTH.

Reset
REQ-026 Reset SHALL asynchronously set PC=RESET_PC, queue empty, no in-flight request, out_valid=0, imem_req=0, misalign_fault=0, out_instr=0, out_pc=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued and in-flight instructions; the first imem_req SHALL occur in the first clock edge cycle after deassertion.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN, when defined: a redirect with redirect_target[1:0] != 0 SHALL set sticky misalign_fault=1, halt fetch (imem_req=0) until the next aligned redirect or reset, and apply the flush.
REQ-029 Without FETCH_MISALIGN_TRAP_EN: port misalign_fault SHALL be absent, and redirect_target[1:0] SHALL be forced to 0 when loaded into PC.

Verification
REQ-030 Reset release with RESET_PC=0 and out_ready=1, imem returning 0x00000013 -> imem_addr 0,4,8,... one per cycle; out_valid from cycle 2, out_pc 0,4,8.
REQ-031 out_ready=0 for 10 cycles -> exactly 4 requests issued (QDEPTH=4), out_pc held at 0, no lost or duplicated PCs after out_ready returns to 1.
REQ-032 Redirect to 0x6 is not legal; redirect to 0x18 while 3 entries are queued -> next cycle out_valid=0, imem_addr=0x18; first out_pc=0x18 two cycles later.
REQ-033 Redirect in the same cycle as pop and in-flight response -> the response is dropped; no entry with the old PC ever appears.
REQ-034 Redirect to 0xFFFF_FFFF_FFFF_FFFC -> next fetches at ...FFFC, then 0x0, 0x4.
REQ-035 With FETCH_MISALIGN_TRAP_EN, redirect to 0x6 -> misalign_fault=1, imem_req=0 held; redirect to 0x20 -> fault clears, fetch resumes at 0x20.
